irrigation_sequencer: RTL and testbench

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

---
 rtl/irrigation_sequencer.sv | 163 ++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: fills the tank when needed, runs the pump for the
// selected duration while counting elapsed time in BCD, and falls back to
// ERROR on sensor faults or a tank that never fills.
module irrigation_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       start,
  input  logic [1:0] preset,
  input  logic       low_level_sensor,
  input  logic       high_level_sensor,
  input  logic       humidity_ok,
  input  logic       clear_error,
  output logic       fill_valve,
  output logic       pump,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] unit_seconds,
  output logic [2:0] dozen_seconds,
  output logic [3:0] unit_minutes,
  output logic [1:0] dozen_minutes
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_IRRIGATE,
    S_DONE,
    S_ERROR
  } state_t;

  // Fill watchdog limit in seconds
  localparam logic [8:0] WD_LIMIT = 9'd300;

  state_t     state;
  logic [1:0] preset_lat;
  logic [8:0] watchdog;
  logic       sensor_fault;
  logic       at_target;

  // Tank reported full while also below minimum cannot be physical
  assign sensor_fault = high_level_sensor & ~low_level_sensor;

  // Run is complete when the timer shows preset*10 minutes exactly
  assign at_target = (dozen_minutes == preset_lat) && (unit_minutes == 4'd0) &&
                     (dozen_seconds == 3'd0) && (unit_seconds == 4'd0);

  // Sequencer state, BCD timer, watchdog and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      preset_lat    <= 2'b00;
      watchdog      <= 9'd0;
      fill_valve    <= 1'b0;
      pump          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      unit_seconds  <= 4'd0;
      dozen_seconds <= 3'd0;
      unit_minutes  <= 4'd0;
      dozen_minutes <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (preset != 2'b00) && !humidity_ok) begin
            preset_lat    <= preset;
            watchdog      <= 9'd0;
            unit_seconds  <= 4'd0;
            dozen_seconds <= 3'd0;
            unit_minutes  <= 4'd0;
            dozen_minutes <= 2'd0;
            busy          <= 1'b1;
            if (high_level_sensor) begin
              state <= S_IRRIGATE;
              pump  <= 1'b1;
            end else begin
              state      <= S_FILL;
              fill_valve <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (sensor_fault || (watchdog >= WD_LIMIT)) begin
            state      <= S_ERROR;
            error      <= 1'b1;
            fill_valve <= 1'b0;
            pump       <= 1'b0;
            busy       <= 1'b0;
          end else if (high_level_sensor) begin
            state      <= S_IRRIGATE;
            fill_valve <= 1'b0;
            pump       <= 1'b1;
          end else if (tick_1s) begin
            watchdog <= watchdog + 9'd1;
          end
        end

        S_IRRIGATE: begin
          if (sensor_fault) begin
            state      <= S_ERROR;
            error      <= 1'b1;
            fill_valve <= 1'b0;
            pump       <= 1'b0;
            busy       <= 1'b0;
          end else if (at_target || humidity_ok) begin
            // Completion and moisture abort both end the run with the timer frozen
            state <= S_DONE;
            pump  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!low_level_sensor) begin
            state      <= S_FILL;
            watchdog   <= 9'd0;
            pump       <= 1'b0;
            fill_valve <= 1'b1;
          end else if (tick_1s) begin
            // All digit carries resolve on the same tick
            if (unit_seconds == 4'd9) begin
              unit_seconds <= 4'd0;
              if (dozen_seconds == 3'd5) begin
                dozen_seconds <= 3'd0;
                if (unit_minutes == 4'd9) begin
                  unit_minutes  <= 4'd0;
                  dozen_minutes <= dozen_minutes + 2'd1;
                end else begin
                  unit_minutes <= unit_minutes + 4'd1;
                end
              end else begin
                dozen_seconds <= dozen_seconds + 3'd1;
              end
            end else begin
              unit_seconds <= unit_seconds + 4'd1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        S_ERROR: begin
          if (clear_error) begin
            state <= S_IDLE;
            error <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          fill_valve <= 1'b0;
          pump       <= 1'b0;
          busy       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Testbench for irrigation_sequencer: scenario runs push expected end-of-run
// events (done pulse or error entry, with the elapsed time in seconds) into a
// queue; a monitor pops and compares whenever the DUT reports one.
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1s = 1'b0;
  logic       start = 1'b0;
  logic [1:0] preset = 2'b00;
  logic       low_level_sensor = 1'b1;
  logic       high_level_sensor = 1'b1;
  logic       humidity_ok = 1'b0;
  logic       clear_error = 1'b0;
  logic       fill_valve, pump, busy, done, error;
  logic [3:0] unit_seconds;
  logic [2:0] dozen_seconds;
  logic [3:0] unit_minutes;
  logic [1:0] dozen_minutes;

  irrigation_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .tick_1s           (tick_1s),
    .start             (start),
    .preset            (preset),
    .low_level_sensor  (low_level_sensor),
    .high_level_sensor (high_level_sensor),
    .humidity_ok       (humidity_ok),
    .clear_error       (clear_error),
    .fill_valve        (fill_valve),
    .pump              (pump),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .unit_seconds      (unit_seconds),
    .dozen_seconds     (dozen_seconds),
    .unit_minutes      (unit_minutes),
    .dozen_minutes     (dozen_minutes)
  );

  always #5 clk = ~clk;

  // kind 0 = done pulse, kind 1 = error entry; secs = elapsed time shown then
  typedef struct {
    int kind;
    int secs;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tsec();
    return int'(unit_seconds) + 10 * int'(dozen_seconds) +
           60 * (int'(unit_minutes) + 10 * int'(dozen_minutes));
  endfunction

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at %0d s, expected none (t=%0t)",
               kind, tsec(), $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_time", tsec(), e.secs);
    end
  endtask

  // Monitor: every done cycle and every error entry must match the next expectation
  always @(negedge clk) begin
    if (done === 1'b1) check_event(0);
    if (error === 1'b1 && err_prev !== 1'b1) check_event(1);
    err_prev = error;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    cyc(1);
  endtask

  task automatic refill(input int s);
    int k;
    low_level_sensor  = 1'b0;
    high_level_sensor = 1'b0;
    cyc(1);
    chk("refill_valve_on", int'(fill_valve), 1);
    chk("refill_pump_off", int'(pump), 0);
    chk("refill_timer_held", tsec(), s);
    k = int'($urandom_range(1, 5));
    repeat (k) one_tick();
    chk("refill_timer_still", tsec(), s);
    low_level_sensor  = 1'b1;
    high_level_sensor = 1'b1;
    cyc(1);
    chk("resume_pump_on", int'(pump), 1);
    chk("resume_valve_off", int'(fill_valve), 0);
  endtask

  // One irrigation run; abort_at / refill_at of -1 mean "not in this run"
  task automatic run(input int p, input int abort_at, input int refill_at);
    int target;
    int stop_at;
    target  = p * 600;
    stop_at = (abort_at >= 0) ? abort_at : target;
    low_level_sensor  = 1'b1;
    high_level_sensor = 1'b1;
    humidity_ok       = 1'b0;
    exp_q.push_back('{0, stop_at});
    preset = 2'(p);
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("run_pump_on", int'(pump), 1);
    chk("run_busy", int'(busy), 1);
    chk("run_valve_off", int'(fill_valve), 0);
    chk("run_timer_clear", tsec(), 0);
    for (int s = 0; s < stop_at; s++) begin
      if (s == refill_at) refill(s);
      tick_1s = 1'b1;
      cyc(1);
      tick_1s = 1'b0;
      chk("timer_step", tsec(), s + 1);
      cyc(1);
    end
    if (abort_at >= 0) begin
      humidity_ok = 1'b1;
      cyc(1);
      humidity_ok = 1'b0;
    end
    cyc(2);
    chk("end_busy_off", int'(busy), 0);
    chk("end_pump_off", int'(pump), 0);
    chk("end_done_cleared", int'(done), 0);
    chk("end_timer_held", tsec(), stop_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int p, ab, rf;

    // Reset state
    cyc(2);
    chk("rst_pump", int'(pump), 0);
    chk("rst_valve", int'(fill_valve), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_timer", tsec(), 0);
    reset = 1'b0;
    cyc(2);

    // Preset 10 minutes, straight run to 10:00
    run(1, -1, -1);
    // Low level at 04:59, refill, resume to 05:00 and on
    run(1, -1, 299);
    // 30 minute run through every carry, ending at 30:00
    run(3, -1, -1);
    // Moisture abort at 02:00
    run(1, 120, -1);

    // Ignored starts: preset 00, then humidity already satisfied
    preset = 2'b00;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk("ign_preset_busy", int'(busy), 0);
    chk("ign_preset_pump", int'(pump), 0);
    chk("ign_preset_valve", int'(fill_valve), 0);
    chk("ign_timer_held", tsec(), 120);
    preset      = 2'b01;
    humidity_ok = 1'b1;
    start       = 1'b1;
    cyc(1);
    start       = 1'b0;
    humidity_ok = 1'b0;
    cyc(1);
    chk("ign_humid_busy", int'(busy), 0);
    chk("ign_humid_pump", int'(pump), 0);

    // Tank never fills: watchdog error after 300 s
    low_level_sensor  = 1'b1;
    high_level_sensor = 1'b0;
    exp_q.push_back('{1, 0});
    preset = 2'b01;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("wd_valve_on", int'(fill_valve), 1);
    chk("wd_pump_off", int'(pump), 0);
    chk("wd_busy", int'(busy), 1);
    repeat (299) one_tick();
    chk("wd_no_error_299", int'(error), 0);
    chk("wd_valve_still", int'(fill_valve), 1);
    one_tick();
    chk("wd_error", int'(error), 1);
    chk("wd_valve_off", int'(fill_valve), 0);
    chk("wd_busy_off", int'(busy), 0);
    repeat (3) one_tick();
    chk("wd_error_held", int'(error), 1);
    clear_error = 1'b1;
    cyc(1);
    clear_error = 1'b0;
    cyc(1);
    chk("wd_cleared", int'(error), 0);
    chk("wd_idle_busy", int'(busy), 0);

    // Sensor fault during irrigation
    high_level_sensor = 1'b1;
    low_level_sensor  = 1'b1;
    preset = 2'b10;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    repeat (3) one_tick();
    exp_q.push_back('{1, 3});
    low_level_sensor = 1'b0;
    cyc(1);
    chk("fault_error", int'(error), 1);
    chk("fault_pump_off", int'(pump), 0);
    low_level_sensor = 1'b1;
    clear_error      = 1'b1;
    cyc(1);
    clear_error = 1'b0;
    cyc(1);
    chk("fault_cleared", int'(error), 0);

    // Randomized runs
    for (int i = 0; i < 3; i++) begin
      p  = int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, p * 600 - 1)) : -1;
      rf = int'($urandom_range(1, p * 600 - 2));
      run(p, ab, rf);
    end

    // Asynchronous reset between clock edges during irrigation
    high_level_sensor = 1'b1;
    low_level_sensor  = 1'b1;
    preset = 2'b01;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    repeat (5) one_tick();
    chk("pre_async_pump", int'(pump), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pump", int'(pump), 0);
    chk("async_valve", int'(fill_valve), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_error", int'(error), 0);
    chk("async_timer", tsec(), 0);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    chk("post_reset_idle", int'(busy), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
